nios_irq_sched: RTL

//  Programmable interrupt scheduler placed between the key/button PIO inputs and the Nios II irq line.
//  - Synchronises and edge-detects N_IRQ raw inputs, then latches each edge as a pending request.
//  - Applies a software mask and picks one request by fixed or rotating priority.
//  - Raises a single CPU irq, then runs an acknowledge/EOI handshake over an Avalon-MM slave.

---
 rtl/nios_irq_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/nios_irq_sched.sv
// nios_irq_sched: edge-capturing interrupt scheduler with mask, fixed/rotating
// priority and an acknowledge/EOI handshake over an Avalon-MM slave.
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   address[1:0]           0 PEND (RO, W1C), 1 MASK (RW), 2 VECTOR (RO, ack), 3 CTRL
//   chipselect, write_n    write = chipselect & ~write_n, read = chipselect & write_n
//   writedata[31:0]        write data
//   readdata[31:0]         registered read data, valid one clock after the read
//   in_port[N_IRQ-1:0]     raw asynchronous request inputs
//   irq                    level interrupt to the CPU
module nios_irq_sched #(
  parameter int N_IRQ    = 4,
  parameter bit EDGE_POL = 1'b0,
  parameter bit ROT_RST  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [N_IRQ-1:0] in_port,
  output logic             irq
);
  localparam int IDX_W = $clog2(N_IRQ);
  localparam logic [N_IRQ-1:0] IDLE_LVL = {N_IRQ{~EDGE_POL}};
  typedef enum logic [1:0] {IDLE = 2'd0, PEND_ST = 2'd1, INSERV = 2'd2} state_t;
  state_t           r_state, w_state_nx;
  logic [N_IRQ-1:0] r_sync1, r_sync2, r_sync3, r_pend, r_mask;
  logic [IDX_W-1:0] r_cur_idx, r_rr_ptr;
  logic             r_rotate, r_irq;
  logic [31:0]      r_readdata, w_rdata;
  logic             w_rd, w_wr, w_ack, w_eoi, w_unused;
  logic [N_IRQ-1:0] w_edge, w_elig, w_clr;
  logic [IDX_W-1:0] w_win, w_start;
  logic [IDX_W:0]   w_sum, w_pos;
  assign w_rd     = chipselect & write_n;
  assign w_wr     = chipselect & ~write_n;
  assign w_edge   = EDGE_POL ? (r_sync2 & ~r_sync3) : (~r_sync2 & r_sync3);
  assign w_elig   = r_pend & r_mask;
  assign w_start  = r_rotate ? r_rr_ptr : '0;
  assign w_unused = ^writedata;
  assign readdata = r_readdata;
  assign irq      = r_irq;
  // Walk downward so the last hit kept is the first one at or after w_start.
  always_comb begin
    w_win = '0;
    w_sum = '0;
    w_pos = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_start} + (IDX_W + 1)'(k);
      w_pos = (w_sum >= (IDX_W + 1)'(N_IRQ)) ? w_sum - (IDX_W + 1)'(N_IRQ) : w_sum;
      if (w_elig[w_pos[IDX_W-1:0]]) w_win = w_pos[IDX_W-1:0];
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_ack      = 1'b0;
    w_eoi      = 1'b0;
    case (r_state)
      IDLE:    if (|w_elig) w_state_nx = PEND_ST;
      PEND_ST: begin
        if (~|w_elig) w_state_nx = IDLE;
        else if (w_rd && address == 2'd2) begin
          w_ack      = 1'b1;
          w_state_nx = INSERV;
        end
      end
      INSERV:  if (w_wr && address == 2'd3 && writedata[0]) begin
        w_eoi      = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  // The acknowledged winner is cleared alongside any software W1C; new edges still win.
  assign w_clr = ((w_wr && address == 2'd0) ? writedata[N_IRQ-1:0] : '0) |
                 (w_ack ? ({{(N_IRQ-1){1'b0}}, 1'b1} << w_win) : '0);
  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0: w_rdata = 32'(r_pend);
      2'd1: w_rdata = 32'(r_mask);
      2'd2: w_rdata = w_ack ? {1'b1, 31'(w_win)} :
                      (r_state == INSERV) ? {1'b1, 31'(r_cur_idx)} : 32'd0;
      default: w_rdata = {23'd0, r_rotate, 5'd0, r_state, 1'b0};
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= IDLE_LVL;
      r_sync2    <= IDLE_LVL;
      r_sync3    <= IDLE_LVL;
      r_pend     <= '0;
      r_mask     <= '0;
      r_cur_idx  <= '0;
      r_rr_ptr   <= '0;
      r_rotate   <= ROT_RST;
      r_state    <= IDLE;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pend  <= (r_pend & ~w_clr) | w_edge;
      r_state <= w_state_nx;
      r_irq   <= (w_state_nx == PEND_ST);
      if (w_rd) r_readdata <= w_rdata;
      if (w_wr && address == 2'd1) r_mask <= writedata[N_IRQ-1:0];
      if (w_wr && address == 2'd3) r_rotate <= writedata[8];
      if (w_ack) r_cur_idx <= w_win;
      if (w_eoi && r_rotate)
        r_rr_ptr <= (r_cur_idx == IDX_W'(N_IRQ - 1)) ? '0 : r_cur_idx + 1'b1;
    end
  end
endmodule
